// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared constants and state encoding for the PC sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package pc_seq_pkg;

   localparam int PC_W = 4;

   // 2'b11 is deliberately left unencoded; the sequencer recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      EXEC  = 2'b10
   } seq_state_t;

endpackage : pc_seq_pkg
`default_nettype wire

// File: rtl/COUNTER4B.sv
`default_nettype none
// ============================================================================
// Module      : COUNTER4B
// Description : 4-bit program counter. Synchronous active-high reset, parallel
//               load when load=1, modulo-16 increment when load=0.
// Revision    : 1.0  initial release
// ============================================================================
module COUNTER4B
   import pc_seq_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [PC_W-1:0] in,
   output logic [PC_W-1:0] out
);

   logic [PC_W-1:0] cnt_d;
   logic [PC_W-1:0] cnt_q;

   // Select the next count: load value or increment (wraps naturally at 4 bits).
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (load) begin
         cnt_d = in;
      end
   end

   // Counter storage with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign out = cnt_q;

endmodule : COUNTER4B
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch/execute sequencer driving a COUNTER4B program counter.
//               Issues one fetch strobe per two-cycle fetch/execute pair and
//               decides every cycle whether the PC holds, loads or increments.
// Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer
   import pc_seq_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [PC_W-1:0] start_addr,
   input  logic            halt,
   input  logic            stall,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_addr,
   output logic [PC_W-1:0] pc,
   output logic            fetch,
   output logic            busy,
   output logic            wrapped
);

   seq_state_t      state_d;
   seq_state_t      state_q;
   logic            wrapped_d;
   logic            wrapped_q;
   logic            cnt_load;
   logic [PC_W-1:0] cnt_in;

   // The counter owns the PC; hold is expressed as reloading the current value.
   COUNTER4B u_counter (
      .clk   (clk),
      .reset (reset),
      .load  (cnt_load),
      .in    (cnt_in),
      .out   (pc)
   );

   // Next-state decode and counter-control mux; default is hold PC, stay put.
   always_comb begin
      state_d   = state_q;
      cnt_load  = 1'b1;
      cnt_in    = pc;
      wrapped_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_in  = start_addr;
               state_d = FETCH;
            end
         end
         FETCH: begin
            state_d = EXEC;
         end
         EXEC: begin
            if (halt) begin
               state_d = IDLE;
            end else if (stall) begin
               state_d = EXEC;
            end else if (jump) begin
               cnt_in  = jump_addr;
               state_d = FETCH;
            end else begin
               // Only a true increment from all-ones can flag a wrap.
               cnt_load  = 1'b0;
               wrapped_d = (pc == {PC_W{1'b1}});
               state_d   = FETCH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register and registered wrap pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         wrapped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign fetch   = (state_q == FETCH);
   assign busy    = (state_q == FETCH) || (state_q == EXEC);
   assign wrapped = wrapped_q;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] start_addr;
   logic       halt;
   logic       stall;
   logic       jump;
   logic [3:0] jump_addr;
   logic [3:0] pc;
   logic       fetch;
   logic       busy;
   logic       wrapped;

   int n_checks;
   int n_fail;

   pc_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .start_addr (start_addr),
      .halt       (halt),
      .stall      (stall),
      .jump       (jump),
      .jump_addr  (jump_addr),
      .pc         (pc),
      .fetch      (fetch),
      .busy       (busy),
      .wrapped    (wrapped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare all observable outputs against hand-computed values.
   task automatic expect_all(input string tag, input logic [3:0] e_pc,
                             input logic e_fetch, input logic e_busy,
                             input logic e_wrap);
      check({tag, ".pc"},      {28'd0, pc},      {28'd0, e_pc});
      check({tag, ".fetch"},   {31'd0, fetch},   {31'd0, e_fetch});
      check({tag, ".busy"},    {31'd0, busy},    {31'd0, e_busy});
      check({tag, ".wrapped"}, {31'd0, wrapped}, {31'd0, e_wrap});
   endtask

   task automatic clear_ctl();
      start = 1'b0; halt = 1'b0; stall = 1'b0; jump = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clear_ctl();
      start_addr = 4'h0;
      jump_addr  = 4'h0;

      // Reset wins over a simultaneous start.
      reset = 1'b1; start = 1'b1; start_addr = 4'b0101;
      #1;
      tick();
      expect_all("reset", 4'h0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0; clear_ctl();
      tick();
      expect_all("idle_after_reset", 4'h0, 1'b0, 1'b0, 1'b0);

      // Start at 0011 and count.
      start = 1'b1; start_addr = 4'b0011;
      tick();
      expect_all("start_fetch", 4'h3, 1'b1, 1'b1, 1'b0);
      // All inputs ignored in FETCH.
      start = 1'b1; start_addr = 4'hF; jump = 1'b1; jump_addr = 4'h9; halt = 1'b1; stall = 1'b1;
      tick();
      clear_ctl();
      expect_all("exec0", 4'h3, 1'b0, 1'b1, 1'b0);
      tick();
      expect_all("fetch1", 4'h4, 1'b1, 1'b1, 1'b0);
      tick();
      expect_all("exec1", 4'h4, 1'b0, 1'b1, 1'b0);
      // start ignored in EXEC.
      start = 1'b1; start_addr = 4'hC;
      tick();
      clear_ctl();
      expect_all("fetch2", 4'h5, 1'b1, 1'b1, 1'b0);
      tick();
      expect_all("exec2", 4'h5, 1'b0, 1'b1, 1'b0);

      // Three stall cycles then jump to 1010.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_all($sformatf("stall%0d", i), 4'h5, 1'b0, 1'b1, 1'b0);
      end
      stall = 1'b0; jump = 1'b1; jump_addr = 4'b1010;
      tick();
      clear_ctl();
      expect_all("jump_fetch", 4'hA, 1'b1, 1'b1, 1'b0);
      tick();
      expect_all("jump_exec", 4'hA, 1'b0, 1'b1, 1'b0);

      // halt beats stall and jump.
      halt = 1'b1; stall = 1'b1; jump = 1'b1; jump_addr = 4'h2;
      tick();
      clear_ctl();
      expect_all("halt", 4'hA, 1'b0, 1'b0, 1'b0);
      // jump/halt ignored in IDLE.
      jump = 1'b1; halt = 1'b1; stall = 1'b1; jump_addr = 4'h7;
      tick();
      expect_all("idle_ignore", 4'hA, 1'b0, 1'b0, 1'b0);
      // Restart with jump still high (ignored).
      halt = 1'b0; stall = 1'b0;
      start = 1'b1; start_addr = 4'b0001;
      tick();
      clear_ctl();
      expect_all("restart", 4'h1, 1'b1, 1'b1, 1'b0);
      tick();
      expect_all("restart_exec", 4'h1, 1'b0, 1'b1, 1'b0);

      // Halt, then run from 1110 through the wrap.
      halt = 1'b1;
      tick();
      clear_ctl();
      expect_all("halt2", 4'h1, 1'b0, 1'b0, 1'b0);
      start = 1'b1; start_addr = 4'b1110;
      tick();
      clear_ctl();
      expect_all("w_fetchE", 4'hE, 1'b1, 1'b1, 1'b0);
      tick();
      expect_all("w_execE", 4'hE, 1'b0, 1'b1, 1'b0);
      tick();
      expect_all("w_fetchF", 4'hF, 1'b1, 1'b1, 1'b0);
      tick();
      expect_all("w_execF", 4'hF, 1'b0, 1'b1, 1'b0);
      tick();
      expect_all("w_fetch0", 4'h0, 1'b1, 1'b1, 1'b1);
      tick();
      expect_all("w_exec0", 4'h0, 1'b0, 1'b1, 1'b0);

      // Jump to 1111, then jump to 0000: no wrap pulse.
      jump = 1'b1; jump_addr = 4'hF;
      tick();
      clear_ctl();
      expect_all("jF_fetch", 4'hF, 1'b1, 1'b1, 1'b0);
      tick();
      expect_all("jF_exec", 4'hF, 1'b0, 1'b1, 1'b0);
      jump = 1'b1; jump_addr = 4'h0;
      tick();
      clear_ctl();
      expect_all("j0_fetch", 4'h0, 1'b1, 1'b1, 1'b0);

      // Reset mid-operation with competing inputs.
      reset = 1'b1; start = 1'b1; jump = 1'b1; halt = 1'b1; start_addr = 4'h6; jump_addr = 4'h9;
      tick();
      reset = 1'b0; clear_ctl();
      expect_all("mid_reset", 4'h0, 1'b0, 1'b0, 1'b0);
      tick();
      expect_all("post_reset", 4'h0, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pc_sequencer
`default_nettype wire
